// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for mux select controllers: FSM state encodings and clog2.
// No logic, no latency.
// No flow control; types and helpers only.
package mux_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotating-priority search: first requester at or after ptr, wrapping modulo N.
// Purely combinational, zero latency.
// No flow control; found_o=0 when nobody requests.
module rr_pick
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            found_o,
    output logic [SELW-1:0] idx_o
);

    localparam int IW = clog2(2 * N);

    // Doubling the request vector turns the wrap-around search into a linear one.
    logic [2*N-1:0] dbl;
    logic [IW-1:0]  pos;
    logic [IW-1:0]  wrap;

    assign dbl = {req_i, req_i};

    // Scan from the far end down so the closest hit to ptr wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        pos     = '0;
        wrap    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'(ptr_i) + IW'(k);
            if (dbl[pos]) begin
                found_o = 1'b1;
                wrap    = (pos >= IW'(N)) ? (pos - IW'(N)) : pos;
                idx_o   = wrap[SELW-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared N:1 mux, with bounded tenure.
// Request to grant is 1 cycle; each release is followed by one dead GAP cycle.
// Requesters wait by holding req; a grant ends on done, req drop or MAX_HOLD cycles.
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int SELW     = 2,
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    done,
    input  logic [N*DW-1:0] din,
    output logic [DW-1:0]   dout,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] sel,
    output logic            valid
);

    localparam int HW = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;

    state_e          state_q;
    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] sel_q;
    logic [N-1:0]    grant_q;
    logic            valid_q;
    logic [HW-1:0]   hold_q;

    logic            pick_found;
    logic [SELW-1:0] pick_idx;
    logic            release_hit;
    logic [SELW-1:0] ptr_d;
    logic [N-1:0]    grant_d;
    logic [DW-1:0]   lanes [N];

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Only the current holder's done/req matter; other lanes are ignored while busy.
    assign release_hit = done[sel_q] | ~req[sel_q] | (hold_q == HW'(MAX_HOLD - 1));

    // After a release the lane just served drops to lowest priority.
    assign ptr_d   = (sel_q == SELW'(N - 1)) ? '0 : (sel_q + 1'b1);
    assign grant_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lanes[i] = din[i*DW +: DW];
    end

    // Arbitration FSM with registered grant/sel/valid; reset drops a live grant at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_q <= grant_d;
                        sel_q   <= pick_idx;
                        valid_q <= 1'b1;
                        hold_q  <= '0;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (release_hit) begin
                        grant_q <= '0;
                        valid_q <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= ST_GAP;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Data path: selected lane while a grant is live, zero otherwise (sel may be stale).
    always_comb begin
        dout = '0;
        if (valid_q) begin
            dout = lanes[sel_q];
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed stimulus with a tenure scoreboard for mux_rr_arbiter.
// Driver pushes expected grants (lane, length, idle gap); monitor checks on negedges.
// Inputs change 1 time unit after posedge; outputs sampled on negedge.
module tb_mux_rr_arbiter;

    localparam int N        = 4;
    localparam int SELW     = 2;
    localparam int DW       = 1;
    localparam int MAX_HOLD = 8;

    typedef struct {
        int lane;
        int len;
        int gap;
    } exp_t;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic [N-1:0]    req   = '0;
    logic [N-1:0]    done  = '0;
    logic [N*DW-1:0] din_v = 4'b0101;
    logic [DW-1:0]   dout;
    logic [N-1:0]    grant;
    logic [SELW-1:0] sel;
    logic            valid;

    int   total = 0;
    int   bad   = 0;
    exp_t expq[$];
    exp_t cur = '{lane: 0, len: -1, gap: -1};
    int   in_ten   = 0;
    int   cur_len  = 0;
    int   idle_cnt = -1;

    always #5 clk = ~clk;

    mux_rr_arbiter #(
        .N        (N),
        .SELW     (SELW),
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .req   (req),
        .done  (done),
        .din   (din_v),
        .dout  (dout),
        .grant (grant),
        .sel   (sel),
        .valid (valid)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push(input int lane, input int len, input int gap);
        exp_t e;
        e.lane = lane;
        e.len  = len;
        e.gap  = gap;
        expq.push_back(e);
    endfunction

    // Monitor: tracks grant tenures and compares them against the scoreboard queue.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", int'(valid), 0);
            chk("rst_grant", int'(grant), 0);
            chk("rst_dout", int'(dout), 0);
            if (in_ten != 0) begin
                chk("tenure_len", cur_len, cur.len);
                in_ten = 0;
            end
            idle_cnt = -1;
        end else if (valid) begin
            if (in_ten == 0) begin
                in_ten  = 1;
                cur_len = 0;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got sel=%0d, expected no grant", sel);
                    cur = '{lane: int'(sel), len: -1, gap: -1};
                end else begin
                    cur = expq.pop_front();
                    chk("grant_sel", int'(sel), cur.lane);
                    chk("grant_onehot", int'(grant), 1 << cur.lane);
                    if (cur.gap >= 0) begin
                        chk("grant_gap", idle_cnt, cur.gap);
                    end
                end
            end
            cur_len++;
            chk("dout_lane", int'(dout), int'(din_v[cur.lane]));
        end else begin
            if (in_ten != 0) begin
                if (cur.len >= 0) begin
                    chk("tenure_len", cur_len, cur.len);
                end
                in_ten   = 0;
                idle_cnt = 0;
            end
            if (idle_cnt >= 0) begin
                idle_cnt++;
            end
            chk("idle_grant", int'(grant), 0);
            chk("idle_dout", int'(dout), 0);
        end
    end

    initial begin
        // Reset state
        tick(2);
        #2;
        chk("reset_valid", int'(valid), 0);
        chk("reset_grant", int'(grant), 0);
        chk("reset_sel", int'(sel), 0);
        chk("reset_dout", int'(dout), 0);
        tick(1);
        rst = 1'b0;

        // No requests: stay idle
        tick(5);

        // Single requester on lane 2: done on 3rd busy cycle, then regrant, then req drop
        push(2, 3, -1);
        push(2, 2, 2);
        req = 4'b0100;
        tick(3);
        done = 4'b0100;
        tick(1);
        done = 4'b0000;
        chk("gap_sel_hold", int'(sel), 2);
        chk("gap_dout_zero", int'(dout), 0);
        tick(3);
        req = 4'b0000;
        tick(3);

        // Reset so the rotation starts from pointer 0
        rst = 1'b1;
        tick(2);
        rst = 1'b0;

        // All requesting, no done: full MAX_HOLD tenures rotating 0,1,2,3,0
        push(0, 8, -1);
        push(1, 8, 2);
        push(2, 8, 2);
        push(3, 8, 2);
        push(0, 8, 2);
        req = 4'b1111;
        tick(49);
        req = 4'b0000;
        tick(3);

        // Lane 3 released by its req drop while done[1] pulses; lane 0 next
        push(3, 2, 4);
        push(0, 3, 2);
        push(2, 2, 2);
        push(0, 2, -1);
        req = 4'b1001;
        tick(2);
        req  = 4'b0001;
        done = 4'b0010;
        tick(1);
        done = 4'b0000;
        // done on a non-granted lane must not cut lane 0's tenure
        tick(3);
        done = 4'b0100;
        tick(1);
        done = 4'b0000;
        req  = 4'b0100;
        tick(5);

        // Asynchronous reset between edges while lane 2 holds the grant
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(valid), 0);
        chk("async_rst_grant", int'(grant), 0);
        chk("async_rst_dout", int'(dout), 0);
        tick(2);
        rst = 1'b0;
        req = 4'b1001;
        tick(2);
        req = 4'b0000;
        tick(4);

        chk("queue_drained", expq.size(), 0);
        chk("no_open_tenure", in_ten, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
